// File: rtl/bram2arbiter_fifo_datamover_pkg.sv
// ---------------------------------------------------------------------------
// bram2arb_pkg
// Shared types for the BRAM-to-arbiter FIFO data mover.
//   state_e      : transfer FSM state (IDLE / RUN)
//   DEF_*        : default parameter values used by the top and its interface
// ---------------------------------------------------------------------------
package bram2arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_BRAM_ADDRWIDTH = 10;
  localparam int DEF_DATAWIDTH      = 1024;
  localparam int DEF_DEPTH          = 4;
  localparam int DEF_CNTWIDTH       = 16;

endpackage

// File: rtl/bram2arbiter_fifo_datamover_if.sv
// ---------------------------------------------------------------------------
// bram2arbiter_fifo_datamover_if
// Bundles the producer (BRAM-style write port) and the arbiter write channel.
//   bram_addr/bram_wrdata/bram_en/bram_we : producer beat
//   wr_req/wr_gnt                         : arbiter handshake
//   wr_addr/wr_data                       : head beat presented to arbiter
// Modports:
//   slave  : the data mover (consumes producer beats, drives the request)
//   master : the environment (producer + arbiter)
// ---------------------------------------------------------------------------
interface bram2arbiter_fifo_datamover_if #(
  parameter int BRAM_ADDRWIDTH = 10,
  parameter int DATAWIDTH      = 1024
);
  logic [BRAM_ADDRWIDTH-1:0] bram_addr;
  logic [DATAWIDTH-1:0]      bram_wrdata;
  logic                      bram_en;
  logic                      bram_we;
  logic                      wr_req;
  logic                      wr_gnt;
  logic [BRAM_ADDRWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0]      wr_data;

  modport slave (
    input  bram_addr, bram_wrdata, bram_en, bram_we, wr_gnt,
    output wr_req, wr_addr, wr_data
  );

  modport master (
    output bram_addr, bram_wrdata, bram_en, bram_we, wr_gnt,
    input  wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/bram2arbiter_fifo_datamover_fifo.sv
// ---------------------------------------------------------------------------
// dm_sync_fifo
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
//   clk, rst_n      : clock, synchronous active-low reset (control only)
//   push_i, wdata_i : write strobe and data (ignored when full)
//   pop_i           : read strobe (ignored when empty)
//   rdata_o         : head entry, valid whenever empty_o is low
//   level_o         : occupancy; full_o / empty_o decoded from it
// ---------------------------------------------------------------------------
module dm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; only pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/bram2arbiter_fifo_datamover.sv
// ---------------------------------------------------------------------------
// bram2arbiter_fifo_datamover
// Captures producer write beats into a DEPTH-entry FIFO and forwards them to
// an arbiter write channel with req/gnt, under a length-programmed transfer.
//   clk, rst_n         : clock, synchronous active-low reset
//   start_i, len_i     : begin a transfer of len_i beats (IDLE only)
//   busy_o             : transfer in progress
//   full_o/empty_o     : FIFO status; level_o occupancy
//   beat_done_o        : pulse per granted beat
//   done_o             : pulse one cycle after the last beat is granted,
//                        or the cycle after a zero-length start
//   drop_o             : sticky, a producer write was discarded
//   bus                : producer port and arbiter channel (slave modport)
// ---------------------------------------------------------------------------
module bram2arbiter_fifo_datamover
  import bram2arb_pkg::*;
#(
  parameter int BRAM_ADDRWIDTH = DEF_BRAM_ADDRWIDTH,
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CNTWIDTH       = DEF_CNTWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [CNTWIDTH-1:0]        len_i,
  output logic                       busy_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       beat_done_o,
  output logic                       done_o,
  output logic                       drop_o,
  bram2arbiter_fifo_datamover_if.slave bus
);
  typedef struct packed {
    logic [BRAM_ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0]      data;
  } beat_t;

  state_e              state_q, state_d;
  logic [CNTWIDTH-1:0] len_q, acc_q, sent_q;
  logic                drop_q, beat_done_q, last_q, done_q;
  logic                push, pop, last_pop, start_ok, wr_attempt;
  beat_t               wbeat, head;

  assign wr_attempt = bus.bram_en & bus.bram_we;
  assign start_ok   = (state_q == IDLE) & start_i;
  assign push       = wr_attempt & (state_q == RUN) & ~full_o & (acc_q < len_q);
  assign pop        = bus.wr_req & bus.wr_gnt;
  assign last_pop   = (state_q == RUN) & pop & (sent_q == len_q - 1'b1);
  assign wbeat      = '{addr: bus.bram_addr, data: bus.bram_wrdata};

  dm_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wbeat),
    .rdata_o (head),
    .level_o (level_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  // Request follows FIFO occupancy; head is zeroed when nothing is offered.
  assign bus.wr_req  = ~empty_o;
  assign bus.wr_addr = bus.wr_req ? head.addr : '0;
  assign bus.wr_data = bus.wr_req ? head.data : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && len_i != '0) state_d = RUN;
      RUN:     if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == RUN);
  end

  // Counters, sticky drop and completion pulses. done_o is delayed one
  // extra cycle after the last beat so it follows that beat's beat_done_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      acc_q       <= '0;
      sent_q      <= '0;
      drop_q      <= 1'b0;
      beat_done_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q  <= len_i;
        acc_q  <= '0;
        sent_q <= '0;
      end else begin
        if (push) acc_q  <= acc_q + 1'b1;
        if (pop)  sent_q <= sent_q + 1'b1;
      end
      // A discarded write in the same cycle as start still marks a drop.
      if (wr_attempt && !push) drop_q <= 1'b1;
      else if (start_ok)       drop_q <= 1'b0;
      beat_done_q <= pop;
      last_q      <= last_pop;
      done_q      <= last_q | (start_ok & (len_i == '0));
    end
  end

  assign beat_done_o = beat_done_q;
  assign done_o      = done_q;
  assign drop_o      = drop_q;
endmodule

// File: tb/tb_bram2arbiter_fifo_datamover.sv
module tb_bram2arbiter_fifo_datamover;
  localparam int AW = 10;
  localparam int DW = 1024;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [CW-1:0] len_i;
  logic          busy_o, full_o, empty_o, beat_done_o, done_o, drop_o;
  logic [2:0]    level_o;

  bram2arbiter_fifo_datamover_if #(.BRAM_ADDRWIDTH(AW), .DATAWIDTH(DW)) bus();

  bram2arbiter_fifo_datamover #(
    .BRAM_ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .CNTWIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .beat_done_o(beat_done_o), .done_o(done_o), .drop_o(drop_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   beat_cnt = 0;
  int   done_cnt = 0;
  int   last_beat_cyc = 0;
  int   last_done_cyc = 0;
  exp_t exp_q[$];

  function automatic logic [DW-1:0] mkdata(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ a;
    return {32{w}};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: a granted head beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && bus.wr_req && bus.wr_gnt) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got addr %0h, expected no beat", bus.wr_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          n_fail++;
          $display("FAIL pop_order: got addr %0h data[31:0] %0h, expected addr %0h data[31:0] %0h",
                   bus.wr_addr, bus.wr_data[31:0], e.addr, e.data[31:0]);
        end
      end
    end
    if (beat_done_o) begin beat_cnt++; last_beat_cyc = cyc; end
    if (done_o)      begin done_cnt++; last_done_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_bram();
    bus.bram_en = 1'b0; bus.bram_we = 1'b0;
  endtask

  task automatic push_beat(input int a, input bit accepted);
    exp_t e;
    bus.bram_en = 1'b1; bus.bram_we = 1'b1;
    bus.bram_addr = AW'(a); bus.bram_wrdata = mkdata(a);
    if (accepted) begin
      e.addr = AW'(a); e.data = mkdata(a);
      exp_q.push_back(e);
    end
    step();
  endtask

  task automatic do_start(input int len);
    start_i = 1'b1; len_i = CW'(len);
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 40 && done_cnt == d0; k++) step();
    n_chk++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL done_timeout: done_o count %0d, expected %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; len_i = '0; bus.wr_gnt = 1'b0;
    bus.bram_addr = '0; bus.bram_wrdata = '0; idle_bram();
    step(); step();
    rst_n = 1'b1;
    step();
    n_chk++;
    if ({bus.wr_req, full_o, empty_o, busy_o, done_o, beat_done_o, drop_o} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL reset_flags: got req/full/empty/busy/done/bdone/drop %b, expected 0010000",
               {bus.wr_req, full_o, empty_o, busy_o, done_o, beat_done_o, drop_o});
    end
    n_chk++;
    if (level_o !== 3'd0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got level %0d addr %0h, expected 0 0", level_o, bus.wr_addr);
    end
    push_beat(1, 1'b0);
    push_beat(2, 1'b0);
    idle_bram();
    step();
    n_chk++;
    if (drop_o !== 1'b1 || level_o !== 3'd0 || bus.wr_req !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drop: got drop %b level %0d req %b busy %b, expected 1 0 0 0",
               drop_o, level_o, bus.wr_req, busy_o);
    end
  endtask

  task automatic test_basic();
    int b0, d0;
    b0 = beat_cnt; d0 = done_cnt;
    bus.wr_gnt = 1'b1;
    do_start(3);
    n_chk++;
    if (busy_o !== 1'b1 || drop_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: got busy %b drop %b, expected 1 0", busy_o, drop_o);
    end
    push_beat(5, 1'b1);
    n_chk++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== AW'(5)) begin
      n_fail++;
      $display("FAIL req_latency: got req %b addr %0h, expected 1 5", bus.wr_req, bus.wr_addr);
    end
    push_beat(6, 1'b1);
    push_beat(7, 1'b1);
    idle_bram();
    wait_done(d0);
    step(); step();
    n_chk++;
    if (beat_cnt - b0 != 3 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: got beats %0d dones %0d, expected 3 1", beat_cnt - b0, done_cnt - d0);
    end
    n_chk++;
    if (last_done_cyc != last_beat_cyc + 1) begin
      n_fail++;
      $display("FAIL done_timing: got done at cycle %0d, expected %0d", last_done_cyc, last_beat_cyc + 1);
    end
    n_chk++;
    if (busy_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_end: got busy %b pending %0d, expected 0 0", busy_o, exp_q.size());
    end
  endtask

  task automatic test_full();
    int b0, d0;
    b0 = beat_cnt; d0 = done_cnt;
    bus.wr_gnt = 1'b0;
    do_start(6);
    for (int i = 1; i <= 6; i++) begin
      push_beat(10 + i, i <= 4);
      if (i == 4) begin
        n_chk++;
        if (full_o !== 1'b1 || level_o !== 3'd4 || drop_o !== 1'b0) begin
          n_fail++;
          $display("FAIL full_at4: got full %b level %0d drop %b, expected 1 4 0", full_o, level_o, drop_o);
        end
      end
    end
    idle_bram();
    n_chk++;
    if (drop_o !== 1'b1 || level_o !== 3'd4 || bus.wr_addr !== AW'(11)) begin
      n_fail++;
      $display("FAIL full_drop: got drop %b level %0d head %0h, expected 1 4 b", drop_o, level_o, bus.wr_addr);
    end
    bus.wr_gnt = 1'b1;
    for (int k = 0; k < 5; k++) step();
    n_chk++;
    if (beat_cnt - b0 != 4 || done_cnt != d0 || empty_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drain4: got beats %0d dones %0d empty %b busy %b, expected 4 0 1 1",
               beat_cnt - b0, done_cnt - d0, empty_o, busy_o);
    end
    push_beat(17, 1'b1);
    push_beat(18, 1'b1);
    idle_bram();
    wait_done(d0);
    step();
    n_chk++;
    if (beat_cnt - b0 != 6 || done_cnt - d0 != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: got beats %0d dones %0d busy %b, expected 6 1 0",
               beat_cnt - b0, done_cnt - d0, busy_o);
    end
  endtask

  task automatic test_wrap();
    int d0;
    d0 = done_cnt;
    bus.wr_gnt = 1'b0;
    do_start(10);
    push_beat(20, 1'b1);
    push_beat(21, 1'b1);
    n_chk++;
    if (level_o !== 3'd2) begin
      n_fail++;
      $display("FAIL wrap_prefill: got level %0d, expected 2", level_o);
    end
    bus.wr_gnt = 1'b1;
    for (int i = 22; i < 30; i++) begin
      push_beat(i, 1'b1);
      n_chk++;
      if (level_o !== 3'd2) begin
        n_fail++;
        $display("FAIL wrap_level beat %0d: got level %0d, expected 2", i, level_o);
      end
    end
    idle_bram();
    wait_done(d0);
    step();
    n_chk++;
    if (exp_q.size() != 0 || busy_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end: got pending %0d busy %b empty %b, expected 0 0 1", exp_q.size(), busy_o, empty_o);
    end
  endtask

  task automatic test_zero_len();
    int d0;
    d0 = done_cnt;
    do_start(0);
    n_chk++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: got done %b busy %b, expected 1 0", done_o, busy_o);
    end
    step();
    n_chk++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_len_after: got done %b busy %b dones %0d, expected 0 0 1",
               done_o, busy_o, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    bus.wr_gnt = 1'b0;
    do_start(5);
    push_beat(30, 1'b0);
    push_beat(31, 1'b0);
    push_beat(32, 1'b0);
    idle_bram();
    n_chk++;
    if (level_o !== 3'd3 || bus.wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_queued: got level %0d req %b, expected 3 1", level_o, bus.wr_req);
    end
    rst_n = 1'b0;
    step();
    n_chk++;
    if (empty_o !== 1'b1 || bus.wr_req !== 1'b0 || level_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got empty %b req %b level %0d busy %b, expected 1 0 0 0",
               empty_o, bus.wr_req, level_o, busy_o);
    end
    rst_n = 1'b1;
    bus.wr_gnt = 1'b1;
    for (int k = 0; k < 6; k++) step();
    n_chk++;
    if (done_cnt != d0 || bus.wr_addr !== '0 || drop_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: got dones %0d addr %0h drop %b, expected 0 0 0",
               done_cnt - d0, bus.wr_addr, drop_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
